// File: rtl/rom_read_arbiter.sv
// Two-port arbiter in front of a byte-wide, one-cycle-latency program ROM.
// Serves 8-bit or little-endian 16-bit reads and returns each result with a one-cycle ack.
module rom_read_arbiter #(
    parameter int ADDR_WIDTH     = 9,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic                  p0_wide,
    output logic                  p0_ack,
    output logic [15:0]           p0_data,
    input  logic                  p1_req,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic                  p1_wide,
    output logic                  p1_ack,
    output logic [15:0]           p1_data,
    output logic                  rom_enable,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t                state, state_n;
    logic                  last_grant, last_grant_n;
    logic                  cur_port, cur_port_n;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_n;
    logic                  cur_wide, cur_wide_n;
    logic [7:0]            lo_byte, lo_byte_n;
    logic                  rom_enable_n;
    logic [ADDR_WIDTH-1:0] rom_addr_n;
    logic                  p0_ack_n, p1_ack_n;
    logic [15:0]           p0_data_n, p1_data_n;
    logic                  win;
    logic [15:0]           result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            cur_addr   <= '0;
            cur_wide   <= 1'b0;
            lo_byte    <= 8'h00;
            rom_enable <= 1'b0;
            rom_addr   <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_data    <= 16'h0000;
            p1_data    <= 16'h0000;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            cur_port   <= cur_port_n;
            cur_addr   <= cur_addr_n;
            cur_wide   <= cur_wide_n;
            lo_byte    <= lo_byte_n;
            rom_enable <= rom_enable_n;
            rom_addr   <= rom_addr_n;
            p0_ack     <= p0_ack_n;
            p1_ack     <= p1_ack_n;
            p0_data    <= p0_data_n;
            p1_data    <= p1_data_n;
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        cur_port_n   = cur_port;
        cur_addr_n   = cur_addr;
        cur_wide_n   = cur_wide;
        lo_byte_n    = lo_byte;
        rom_enable_n = rom_enable;
        rom_addr_n   = rom_addr;
        p0_ack_n     = 1'b0;
        p1_ack_n     = 1'b0;
        p0_data_n    = p0_data;
        p1_data_n    = p1_data;
        win          = 1'b0;
        result       = 16'h0000;

        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    // Tie goes to the port that did not win last time, unless fixed priority
                    if (p0_req && p1_req)
                        win = FIXED_PRIORITY ? 1'b0 : ~last_grant;
                    else
                        win = p1_req;
                    cur_port_n   = win;
                    last_grant_n = win;
                    cur_addr_n   = win ? p1_addr : p0_addr;
                    cur_wide_n   = win ? p1_wide : p0_wide;
                    rom_addr_n   = win ? p1_addr : p0_addr;
                    rom_enable_n = 1'b1;
                    state_n      = LO;
                end
            end
            LO: begin
                if (cur_wide) begin
                    rom_addr_n = cur_addr + ADDR_WIDTH'(1);
                    state_n    = HI;
                end else begin
                    state_n = DONE;
                end
            end
            HI: begin
                lo_byte_n = rom_data;
                state_n   = DONE;
            end
            DONE: begin
                result = cur_wide ? {rom_data, lo_byte} : {8'h00, rom_data};
                if (cur_port) begin
                    p1_data_n = result;
                    p1_ack_n  = 1'b1;
                end else begin
                    p0_data_n = result;
                    p0_ack_n  = 1'b1;
                end
                rom_enable_n = 1'b0;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: a round-robin instance and a fixed-priority instance,
// each backed by a 1-cycle ROM returning addr[7:0] ^ 8'h5A.
module tb_rom_read_arbiter;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_wide, p1_req, p1_wide;
    logic [AW-1:0] p0_addr, p1_addr;
    logic          p0_ack, p1_ack, rom_enable, busy;
    logic [15:0]   p0_data, p1_data;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data, rom_q;

    logic          f_p0_req, f_p1_req;
    logic [AW-1:0] f_p0_addr, f_p1_addr;
    logic          f_p0_ack, f_p1_ack, f_rom_enable, f_busy;
    logic [15:0]   f_p0_data, f_p1_data;
    logic [AW-1:0] f_rom_addr;
    logic [7:0]    f_rom_data, f_rom_q;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rom_read_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIORITY(1'b0)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wide(p0_wide), .p0_ack(p0_ack), .p0_data(p0_data),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wide(p1_wide), .p1_ack(p1_ack), .p1_data(p1_data),
        .rom_enable(rom_enable), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    rom_read_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIORITY(1'b1)) dut_fixed (
        .clk(clk), .reset(reset),
        .p0_req(f_p0_req), .p0_addr(f_p0_addr), .p0_wide(1'b0), .p0_ack(f_p0_ack), .p0_data(f_p0_data),
        .p1_req(f_p1_req), .p1_addr(f_p1_addr), .p1_wide(1'b0), .p1_ack(f_p1_ack), .p1_data(f_p1_data),
        .rom_enable(f_rom_enable), .rom_addr(f_rom_addr), .rom_data(f_rom_data), .busy(f_busy)
    );

    always @(posedge clk) rom_q <= rom_enable ? (rom_addr[7:0] ^ 8'h5A) : 8'h00;
    assign rom_data = rom_enable ? rom_q : 8'h00;
    always @(posedge clk) f_rom_q <= f_rom_enable ? (f_rom_addr[7:0] ^ 8'h5A) : 8'h00;
    assign f_rom_data = f_rom_enable ? f_rom_q : 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        p0_req = 0; p0_wide = 0; p0_addr = '0;
        p1_req = 0; p1_wide = 0; p1_addr = '0;
        f_p0_req = 0; f_p1_req = 0; f_p0_addr = '0; f_p1_addr = '0;
        #1;
        n_checks++;
        if ({rom_enable, rom_addr, p0_ack, p1_ack, busy} !== 13'h0)
            $display("FAIL reset_ctrl got=%h exp=0", {rom_enable, rom_addr, p0_ack, p1_ack, busy});
        else n_pass++;
        n_checks++;
        if ({p0_data, p1_data} !== 32'h0)
            $display("FAIL reset_data got=%h exp=0", {p0_data, p1_data});
        else n_pass++;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({busy, rom_enable, f_busy} !== 3'b000)
            $display("FAIL idle_after_reset got=%b exp=000", {busy, rom_enable, f_busy});
        else n_pass++;
    endtask

    task automatic test_narrow();
        p0_req = 1; p0_addr = 9'h004; p0_wide = 0;
        tick(); // E0
        n_checks++;
        if ({rom_enable, busy, rom_addr} !== {2'b11, 9'h004})
            $display("FAIL narrow_grant got=%h exp=%h", {rom_enable, busy, rom_addr}, {2'b11, 9'h004});
        else n_pass++;
        p0_req = 0; p0_addr = 9'h0AA;
        tick(); // E1
        n_checks++;
        if ({p0_ack, p1_ack} !== 2'b00)
            $display("FAIL narrow_early_ack got=%b exp=00", {p0_ack, p1_ack});
        else n_pass++;
        tick(); // E2
        n_checks++;
        if ({p0_ack, p1_ack, rom_enable, busy} !== 4'b1000)
            $display("FAIL narrow_ack got=%b exp=1000", {p0_ack, p1_ack, rom_enable, busy});
        else n_pass++;
        n_checks++;
        if (p0_data !== 16'h005E) $display("FAIL narrow_data got=%h exp=005e", p0_data);
        else n_pass++;
        tick();
        n_checks++;
        if ({p0_ack, p0_data} !== {1'b0, 16'h005E})
            $display("FAIL narrow_hold got=%h exp=%h", {p0_ack, p0_data}, {1'b0, 16'h005E});
        else n_pass++;
    endtask

    task automatic test_wide_wrap();
        p0_req = 1; p0_addr = 9'h1FF; p0_wide = 1;
        tick(); // E0
        n_checks++;
        if (rom_addr !== 9'h1FF) $display("FAIL wrap_addr0 got=%h exp=1ff", rom_addr);
        else n_pass++;
        p0_req = 0;
        tick(); // E1
        n_checks++;
        if (rom_addr !== 9'h000) $display("FAIL wrap_addr1 got=%h exp=000", rom_addr);
        else n_pass++;
        tick(); // E2
        n_checks++;
        if (p0_ack !== 1'b0) $display("FAIL wrap_early_ack got=%b exp=0", p0_ack);
        else n_pass++;
        tick(); // E3
        n_checks++;
        if ({p0_ack, p0_data} !== {1'b1, 16'h5AA5})
            $display("FAIL wrap_data got=%h exp=%h", {p0_ack, p0_data}, {1'b1, 16'h5AA5});
        else n_pass++;
        p0_wide = 0;
        tick();
        n_checks++;
        if (p0_ack !== 1'b0) $display("FAIL wrap_ack_width got=%b exp=0", p0_ack);
        else n_pass++;
    endtask

    task automatic test_wide_p1();
        p1_req = 1; p1_addr = 9'h010; p1_wide = 1;
        tick(); // E0
        n_checks++;
        if (rom_addr !== 9'h010) $display("FAIL wide_addr0 got=%h exp=010", rom_addr);
        else n_pass++;
        // changing addr/wide after grant must not disturb the read in flight
        p1_req = 0; p1_addr = 9'h100; p1_wide = 0;
        tick(); // E1
        n_checks++;
        if (rom_addr !== 9'h011) $display("FAIL wide_addr1 got=%h exp=011", rom_addr);
        else n_pass++;
        tick(); // E2
        n_checks++;
        if (p1_ack !== 1'b0) $display("FAIL wide_early_ack got=%b exp=0", p1_ack);
        else n_pass++;
        tick(); // E3
        n_checks++;
        if ({p1_ack, p0_ack, p1_data} !== {2'b10, 16'h4B4A})
            $display("FAIL wide_data got=%h exp=%h", {p1_ack, p0_ack, p1_data}, {2'b10, 16'h4B4A});
        else n_pass++;
        n_checks++;
        if (p0_data !== 16'h5AA5) $display("FAIL wide_other_hold got=%h exp=5aa5", p0_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic e0, e1;
        p0_req = 1; p0_addr = 9'h020; p0_wide = 0;
        p1_req = 1; p1_addr = 9'h030; p1_wide = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            e0 = (k == 2) || (k == 8);
            e1 = (k == 5) || (k == 11);
            if (k == 0) begin
                n_checks++;
                if (rom_addr !== 9'h020) $display("FAIL b2b_first_grant got=%h exp=020", rom_addr);
                else n_pass++;
            end
            n_checks++;
            if ({p0_ack, p1_ack} !== {e0, e1})
                $display("FAIL b2b_ack k=%0d got=%b exp=%b", k, {p0_ack, p1_ack}, {e0, e1});
            else n_pass++;
            if (e0) begin
                n_checks++;
                if (p0_data !== 16'h007A) $display("FAIL b2b_p0_data k=%0d got=%h exp=007a", k, p0_data);
                else n_pass++;
            end
            if (e1) begin
                n_checks++;
                if (p1_data !== 16'h006A) $display("FAIL b2b_p1_data k=%0d got=%h exp=006a", k, p1_data);
                else n_pass++;
            end
        end
        p0_req = 0; p1_req = 0;
        repeat (2) tick();
    endtask

    task automatic test_fixed();
        logic e0;
        f_p0_req = 1; f_p0_addr = 9'h020;
        f_p1_req = 1; f_p1_addr = 9'h030;
        for (int k = 0; k < 12; k++) begin
            tick();
            e0 = (k == 2) || (k == 5) || (k == 8);
            n_checks++;
            if ({f_p0_ack, f_p1_ack} !== {e0, (k == 11)})
                $display("FAIL fixed_ack k=%0d got=%b exp=%b", k, {f_p0_ack, f_p1_ack}, {e0, (k == 11)});
            else n_pass++;
            if (k == 8) f_p0_req = 0;
        end
        n_checks++;
        if ({f_p0_data, f_p1_data} !== {16'h007A, 16'h006A})
            $display("FAIL fixed_data got=%h exp=%h", {f_p0_data, f_p1_data}, {16'h007A, 16'h006A});
        else n_pass++;
        f_p1_req = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        p0_req = 1; p0_addr = 9'h040; p0_wide = 1;
        tick(); // E0
        p0_req = 0;
        tick(); // E1, now in HI
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({rom_enable, rom_addr, p0_ack, p1_ack, busy, p0_data, p1_data} !== 45'h0)
            $display("FAIL mid_reset_async got=%h exp=0",
                     {rom_enable, rom_addr, p0_ack, p1_ack, busy, p0_data, p1_data});
        else n_pass++;
        repeat (2) tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({p0_ack, p1_ack, busy} !== 3'b000)
                $display("FAIL mid_reset_no_ack k=%0d got=%b exp=000", k, {p0_ack, p1_ack, busy});
            else n_pass++;
        end
        p1_req = 1; p1_addr = 9'h000; p1_wide = 0;
        tick(); // E0
        p1_req = 0;
        tick();
        tick(); // E2
        n_checks++;
        if ({p1_ack, p1_data} !== {1'b1, 16'h005A})
            $display("FAIL post_reset_read got=%h exp=%h", {p1_ack, p1_data}, {1'b1, 16'h005A});
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_wide_wrap();
        test_wide_p1();
        test_back_to_back();
        test_fixed();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
